// File: rtl/bldc_hall_pkg.sv
// Shared hall-sensor definitions: 6-step code constants, neighbour and legality helpers.
package bldc_hall_pkg;

    localparam int unsigned HALL_W = 3;

    // Forward rotation order: STEP_1 -> STEP_2 -> ... -> STEP_6 -> STEP_1
    localparam logic [HALL_W-1:0] STEP_1 = 3'b101;
    localparam logic [HALL_W-1:0] STEP_2 = 3'b100;
    localparam logic [HALL_W-1:0] STEP_3 = 3'b110;
    localparam logic [HALL_W-1:0] STEP_4 = 3'b010;
    localparam logic [HALL_W-1:0] STEP_5 = 3'b011;
    localparam logic [HALL_W-1:0] STEP_6 = 3'b001;

    // Outcome of an accepted code relative to the current locked state
    typedef enum logic [2:0] {
        ACC_INVALID = 3'd0,
        ACC_LOCK    = 3'd1,
        ACC_SAME    = 3'd2,
        ACC_FWD     = 3'd3,
        ACC_REV     = 3'd4,
        ACC_SKIP    = 3'd5
    } acc_kind_e;

    // Forward neighbour of a legal code; illegal codes map to 000
    function automatic logic [HALL_W-1:0] hall_next(input logic [HALL_W-1:0] code);
        logic [HALL_W-1:0] r;
        case (code)
            STEP_1:  r = STEP_2;
            STEP_2:  r = STEP_3;
            STEP_3:  r = STEP_4;
            STEP_4:  r = STEP_5;
            STEP_5:  r = STEP_6;
            STEP_6:  r = STEP_1;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reverse neighbour of a legal code; illegal codes map to 000
    function automatic logic [HALL_W-1:0] hall_prev(input logic [HALL_W-1:0] code);
        logic [HALL_W-1:0] r;
        case (code)
            STEP_1:  r = STEP_6;
            STEP_2:  r = STEP_1;
            STEP_3:  r = STEP_2;
            STEP_4:  r = STEP_3;
            STEP_5:  r = STEP_4;
            STEP_6:  r = STEP_5;
            default: r = '0;
        endcase
        return r;
    endfunction

    // 000 and 111 cannot occur with healthy sensors
    function automatic logic hall_legal(input logic [HALL_W-1:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    // Classify a newly accepted code against the current output state
    function automatic acc_kind_e hall_classify(input logic [HALL_W-1:0] code,
                                                input logic [HALL_W-1:0] cur,
                                                input logic              locked);
        acc_kind_e k;
        if (!hall_legal(code))             k = ACC_INVALID;
        else if (!locked)                  k = ACC_LOCK;
        else if (code == cur)              k = ACC_SAME;
        else if (code == hall_next(cur))   k = ACC_FWD;
        else if (code == hall_prev(cur))   k = ACC_REV;
        else                               k = ACC_SKIP;
        return k;
    endfunction

endpackage

// File: rtl/bldc_hall_filter_sync.sv
// Generic two-flop synchronizer for asynchronous sensor inputs.
module hall_sync #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_d, s1_q;
    logic [WIDTH-1:0] s2_d, s2_q;

    // Shift the raw input through two stages
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchronizer stages with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/bldc_hall_filter.sv
// Hall sensor conditioner: synchronize, debounce, validate 6-step sequence, record faults.
module bldc_hall_filter
    import bldc_hall_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned CNT_WIDTH     = 8,
    parameter int unsigned FAULT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2:0]             hall_raw,
    input  logic                   enable,
    input  logic                   clear_faults,
    output logic [2:0]             hall_out,
    output logic                   hall_valid,
    output logic                   hall_change,
    output logic                   hall_dir,
    output logic                   fault_invalid,
    output logic                   fault_skip,
    output logic [FAULT_WIDTH-1:0] fault_count
);

    localparam logic [CNT_WIDTH-1:0]   CNT_LAST  = CNT_WIDTH'(FILTER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_SAT   = CNT_WIDTH'(FILTER_CYCLES);
    localparam logic [FAULT_WIDTH-1:0] FAULT_MAX = '1;

    logic [2:0] hall_s2;

    logic [2:0]             cand_d, cand_q;
    logic [CNT_WIDTH-1:0]   cnt_d, cnt_q;
    logic [2:0]             hall_out_d, hall_out_q;
    logic                   hall_valid_d, hall_valid_q;
    logic                   hall_change_d, hall_change_q;
    logic                   hall_dir_d, hall_dir_q;
    logic                   fault_invalid_d, fault_invalid_q;
    logic                   fault_skip_d, fault_skip_q;
    logic [FAULT_WIDTH-1:0] fault_count_d, fault_count_q;

    logic      accept;
    logic      inv_event;
    logic      skip_event;
    acc_kind_e kind;

    hall_sync #(.WIDTH(3)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (hall_raw),
        .q       (hall_s2)
    );

    // Stability filter: restart on any change, fire once when the run reaches FILTER_CYCLES
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (hall_s2 != cand_q) begin
            cand_d = hall_s2;
            cnt_d  = '0;
        end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (cnt_q == CNT_LAST) begin
            accept = 1'b1;
            cnt_d  = CNT_SAT;
        end
        if (!enable) begin
            cnt_d  = '0;
            accept = 1'b0;
        end
    end

    // Sequence check on accepted codes and fault bookkeeping
    always_comb begin
        hall_out_d    = hall_out_q;
        hall_valid_d  = hall_valid_q;
        hall_change_d = 1'b0;
        hall_dir_d    = hall_dir_q;
        inv_event     = 1'b0;
        skip_event    = 1'b0;
        kind          = hall_classify(cand_q, hall_out_q, hall_valid_q);

        if (!enable) begin
            hall_valid_d = 1'b0;
        end else if (accept) begin
            case (kind)
                ACC_INVALID: inv_event = 1'b1;
                ACC_LOCK: begin
                    hall_out_d   = cand_q;
                    hall_valid_d = 1'b1;
                end
                ACC_FWD: begin
                    hall_out_d    = cand_q;
                    hall_change_d = 1'b1;
                    hall_dir_d    = 1'b1;
                end
                ACC_REV: begin
                    hall_out_d    = cand_q;
                    hall_change_d = 1'b1;
                    hall_dir_d    = 1'b0;
                end
                ACC_SKIP: begin
                    hall_out_d = cand_q;
                    skip_event = 1'b1;
                end
                default: ;
            endcase
        end

        // A fault in the clearing cycle wins over the clear
        fault_invalid_d = clear_faults ? 1'b0 : fault_invalid_q;
        fault_skip_d    = clear_faults ? 1'b0 : fault_skip_q;
        if (inv_event)  fault_invalid_d = 1'b1;
        if (skip_event) fault_skip_d    = 1'b1;

        if (clear_faults) begin
            fault_count_d = (inv_event || skip_event) ? FAULT_WIDTH'(1) : '0;
        end else if ((inv_event || skip_event) && (fault_count_q != FAULT_MAX)) begin
            fault_count_d = fault_count_q + FAULT_WIDTH'(1);
        end else begin
            fault_count_d = fault_count_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cand_q          <= '0;
            cnt_q           <= '0;
            hall_out_q      <= '0;
            hall_valid_q    <= 1'b0;
            hall_change_q   <= 1'b0;
            hall_dir_q      <= 1'b0;
            fault_invalid_q <= 1'b0;
            fault_skip_q    <= 1'b0;
            fault_count_q   <= '0;
        end else begin
            cand_q          <= cand_d;
            cnt_q           <= cnt_d;
            hall_out_q      <= hall_out_d;
            hall_valid_q    <= hall_valid_d;
            hall_change_q   <= hall_change_d;
            hall_dir_q      <= hall_dir_d;
            fault_invalid_q <= fault_invalid_d;
            fault_skip_q    <= fault_skip_d;
            fault_count_q   <= fault_count_d;
        end
    end

    assign hall_out      = hall_out_q;
    assign hall_valid    = hall_valid_q;
    assign hall_change   = hall_change_q;
    assign hall_dir      = hall_dir_q;
    assign fault_invalid = fault_invalid_q;
    assign fault_skip    = fault_skip_q;
    assign fault_count   = fault_count_q;

endmodule

// File: tb/tb_bldc_hall_filter.sv
// Self-checking bench for bldc_hall_filter: vector table plus hand-written corner sequences.
module tb_bldc_hall_filter;

    localparam int unsigned F = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] hall_raw;
    logic       enable;
    logic       clear_faults;
    logic [2:0] hall_out;
    logic       hall_valid;
    logic       hall_change;
    logic       hall_dir;
    logic       fault_invalid;
    logic       fault_skip;
    logic [7:0] fault_count;

    typedef struct {
        logic [2:0] code;
        logic [2:0] out;
        logic       valid;
        logic       chg;
        logic       dir;
        logic       inv;
        logic       skip;
        logic [7:0] cnt;
    } vec_t;

    vec_t       tbl [12];
    vec_t       sb [$];
    int         checks   = 0;
    int         failures = 0;
    int         pulses   = 0;
    logic       prev_chg = 1'b0;
    logic       dbl      = 1'b0;
    logic [2:0] last_out = 3'b000;

    bldc_hall_filter #(.FILTER_CYCLES(F), .CNT_WIDTH(8), .FAULT_WIDTH(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hall_raw      (hall_raw),
        .enable        (enable),
        .clear_faults  (clear_faults),
        .hall_out      (hall_out),
        .hall_valid    (hall_valid),
        .hall_change   (hall_change),
        .hall_dir      (hall_dir),
        .fault_invalid (fault_invalid),
        .fault_skip    (fault_skip),
        .fault_count   (fault_count)
    );

    always #5 clk = ~clk;

    // Count strobes and catch back-to-back strobes
    always @(negedge clk) begin
        if (hall_change) pulses <= pulses + 1;
        if (hall_change && prev_chg) dbl <= 1'b1;
        prev_chg <= hall_change;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cmp_state(input string tag, input vec_t e);
        check({tag, ".out"},   32'(hall_out),      32'(e.out));
        check({tag, ".valid"}, 32'(hall_valid),    32'(e.valid));
        check({tag, ".chg"},   32'(hall_change),   32'(e.chg));
        check({tag, ".dir"},   32'(hall_dir),      32'(e.dir));
        check({tag, ".inv"},   32'(fault_invalid), 32'(e.inv));
        check({tag, ".skip"},  32'(fault_skip),    32'(e.skip));
        check({tag, ".cnt"},   32'(fault_count),   32'(e.cnt));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] code, input logic [2:0] out, input logic chg,
                                input logic dir, input logic inv, input logic skip,
                                input logic [7:0] cnt);
        vec_t v;
        v.code = code; v.out = out; v.valid = 1'b1; v.chg = chg;
        v.dir = dir; v.inv = inv; v.skip = skip; v.cnt = cnt;
        return v;
    endfunction

    // Drive a code, confirm nothing moves before edge F+3, then check the expected result there
    task automatic apply(input vec_t e, input bit clr, input string tag);
        vec_t got;
        @(negedge clk);
        hall_raw = e.code;
        sb.push_back(e);
        tick(F + 2);
        check({tag, ".early_out"}, 32'(hall_out), 32'(last_out));
        check({tag, ".early_chg"}, 32'(hall_change), 32'(0));
        if (clr) clear_faults = 1'b1;
        tick(1);
        clear_faults = 1'b0;
        got = sb.pop_front();
        cmp_state(tag, got);
        last_out = got.out;
        tick(1);
        check({tag, ".chg_off"}, 32'(hall_change), 32'(0));
        tick(3);
    endtask

    initial begin
        // code, out, chg, dir, inv, skip, cnt
        tbl[0]  = mk(3'b101, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0); // first lock
        tbl[1]  = mk(3'b100, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        tbl[2]  = mk(3'b110, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        tbl[3]  = mk(3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // reverse
        tbl[4]  = mk(3'b101, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        tbl[5]  = mk(3'b111, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1); // invalid
        tbl[6]  = mk(3'b100, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        tbl[7]  = mk(3'b110, 3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        tbl[8]  = mk(3'b011, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2); // skip
        tbl[9]  = mk(3'b001, 3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2);
        tbl[10] = mk(3'b000, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3); // invalid
        tbl[11] = mk(3'b101, 3'b101, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3); // wrap 001->101

        reset_n = 1'b0; hall_raw = 3'b000; enable = 1'b1; clear_faults = 1'b0;
        tick(3);
        check("rst.out",   32'(hall_out),      32'(0));
        check("rst.valid", 32'(hall_valid),    32'(0));
        check("rst.chg",   32'(hall_change),   32'(0));
        check("rst.dir",   32'(hall_dir),      32'(0));
        check("rst.inv",   32'(fault_invalid), 32'(0));
        check("rst.skip",  32'(fault_skip),    32'(0));
        check("rst.cnt",   32'(fault_count),   32'(0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));
        check("vec.pulses", 32'(pulses), 32'(8));

        // Short glitch to a neighbour then back: re-acceptance of the held code is silent
        @(negedge clk);
        hall_raw = 3'b100;
        tick(10);
        hall_raw = 3'b101;
        tick(40);
        cmp_state("glitch", mk(3'b101, 3'b101, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3));
        check("glitch.pulses", 32'(pulses), 32'(8));

        // Plain clear
        @(negedge clk);
        clear_faults = 1'b1;
        tick(1);
        clear_faults = 1'b0;
        cmp_state("clear", mk(3'b101, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));

        // Skip, then a second skip coinciding with clear_faults
        apply(mk(3'b010, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1), 1'b0, "skip1");
        apply(mk(3'b101, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1), 1'b1, "skip_clr");

        // Disable: valid drops, hall_out holds, no faults recorded
        @(negedge clk);
        enable = 1'b0;
        tick(1);
        check("dis.valid", 32'(hall_valid), 32'(0));
        check("dis.out",   32'(hall_out),   32'(3'b101));
        hall_raw = 3'b111;
        tick(30);
        check("dis.inv", 32'(fault_invalid), 32'(0));
        check("dis.cnt", 32'(fault_count),   32'(1));
        hall_raw = 3'b100;
        tick(10);
        @(negedge clk);
        enable = 1'b1;
        tick(F - 1);
        check("reen.valid_early", 32'(hall_valid), 32'(0));
        tick(1);
        cmp_state("reen", mk(3'b100, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));
        last_out = 3'b100;
        apply(mk(3'b110, 3'b110, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1), 1'b0, "reen_step");

        // 300 invalid events: counter saturates
        @(negedge clk);
        clear_faults = 1'b1;
        tick(1);
        clear_faults = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            hall_raw = (i % 2 == 0) ? 3'b000 : 3'b111;
            tick(F + 4);
        end
        check("sat.cnt", 32'(fault_count),   32'(255));
        check("sat.inv", 32'(fault_invalid), 32'(1));
        check("sat.out", 32'(hall_out),      32'(3'b110));

        // Reset in the middle of a filter run
        @(negedge clk);
        hall_raw = 3'b010;
        tick(8);
        @(negedge clk);
        reset_n = 1'b0;
        tick(1);
        cmp_state("midrst", '{code: 3'b000, out: 3'b000, valid: 1'b0, chg: 1'b0,
                              dir: 1'b0, inv: 1'b0, skip: 1'b0, cnt: 8'd0});
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);

        check("pulses.total", 32'(pulses), 32'(9));
        check("no_double",    32'(dbl),    32'(0));
        check("sb.empty",     32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bldc_hall_filter.md
Name: bldc_hall_filter

Overview:
Conditions the raw 3-bit BLDC hall sensor inputs before they reach the hall transition counter and the commutation logic. It first passes the inputs through a two-stage synchronizer. It then accepts a hall code only after that code has been stable for a set number of cycles. Accepted codes are checked against the legal 6-step sequence. The block outputs a clean hall state, a one-cycle strobe for each legal step with its direction, and sticky fault flags with a saturating fault counter for firmware readout.

Parameters:
FILTER_CYCLES, 16, consecutive stable synchronized samples required to accept a code (legal range 1..255)
CNT_WIDTH, 8, width of the stability counter; must hold FILTER_CYCLES
FAULT_WIDTH, 8, width of fault_count

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
hall_raw  in  3  asynchronous hall sensor pins
enable  in  1  1 = filter output and fault recording active
clear_faults  in  1  synchronous clear of the sticky faults and fault_count
hall_out  out  3  last accepted legal hall code
hall_valid  out  1  hall_out holds a code accepted since the last enable or reset
hall_change  out  1  one-cycle strobe on each accepted adjacent step
hall_dir  out  1  direction of the last step: 1 = forward (101→100→110→010→011→001→101), 0 = reverse
fault_invalid  out  1  sticky; an accepted code was 000 or 111
fault_skip  out  1  sticky; an accepted legal code was not adjacent to hall_out
fault_count  out  FAULT_WIDTH  saturating count of fault events

Behaviour:
- Reset (reset_n=0 at a clk edge): sync stages, candidate, stability counter and every output go to 0. Reset takes priority over all other inputs, including during a filter run.
- Synchronizer: hall_s1 <= hall_raw; hall_s2 <= hall_s1.
- Filter, each edge:
  - If hall_s2 != candidate: candidate <= hall_s2 and cnt <= 0.
  - Else if cnt < FILTER_CYCLES-1: cnt++.
  - Else if cnt == FILTER_CYCLES-1: an acceptance event fires and cnt <= FILTER_CYCLES. The counter then saturates there, so each stable code produces exactly one acceptance event.
- Latency: if the first edge to sample a new hall_raw value is edge 1, hall_out and hall_change update at edge FILTER_CYCLES+3.
- Glitches: a glitch shorter than FILTER_CYCLES samples never changes any output. Returning to the current hall_out value and being re-accepted produces no strobe and no fault.
- Acceptance rules (only while enable=1):
  - Code 000 or 111: fault_invalid <= 1, fault_count++; hall_out and hall_valid are unchanged.
  - Legal code while hall_valid=0 (first lock): hall_out <= code, hall_valid <= 1, no hall_change, hall_dir unchanged.
  - Legal code equal to hall_out: no action.
  - Legal code that is the forward or reverse neighbour of hall_out: hall_out <= code, hall_change pulses 1 for one cycle, hall_dir <= 1 for forward or 0 for reverse.
  - Legal code that is not adjacent: fault_skip <= 1, fault_count++, hall_out <= code (resynchronize), no hall_change, hall_dir unchanged.
- enable=0: hall_valid <= 0, hall_change = 0, cnt <= 0, and no faults are recorded. hall_out holds its value. The synchronizer and candidate keep tracking. After re-enable, the currently stable code is taken as a first lock after FILTER_CYCLES samples.
- clear_faults=1: clears fault_invalid, fault_skip and fault_count. If a fault event occurs in the same cycle, the new fault wins: the flag is set and fault_count = 1.
- fault_count: holds at all-ones and does not wrap.
- hall_change is registered and is never high for two consecutive cycles.

Decomposition:
- Package bldc_hall_pkg holds:
  - the STEP_1..STEP_6 code constants (101, 100, 110, 010, 011, 001), shared with the hall counter;
  - function hall_next(code) for the forward neighbour;
  - function hall_prev(code) for the reverse neighbour;
  - function hall_legal(code).
- One sub-module, hall_sync: a parameterized-width two-flop synchronizer, reusable for encoder inputs.

Test Plan:
- Reset, enable=1, hall_raw=101 held → hall_valid rises at edge 19 (FILTER_CYCLES=16), hall_out=101, hall_change never pulses.
- From lock on 101, step to 100, then 110 → one hall_change pulse per step, each 19 edges after the input change, hall_dir=1; then step back 110→100 → pulse with hall_dir=0.
- Locked at 100, inject a 110 glitch lasting 10 cycles, then return to 100 → no output change, no fault.
- Locked at 101, apply 111 for 30 cycles → fault_invalid=1, fault_count=1, hall_out stays 101. Then apply 100 → normal step and pulse.
- Locked at 101, jump to 010 → fault_skip=1, fault_count=1, hall_out=010, no pulse. Pulse clear_faults in the same cycle as a second skip → fault_count=1 and fault_skip=1.
- Force 300 invalid events with FAULT_WIDTH=8 → fault_count saturates at 255. Assert reset_n=0 mid-filter run → all outputs 0 on the next edge.
